axi_stream_header_arbiter: RTL and testbench

- Shares one `axi_stream_insert_header` header-insert port among `NUM_SRC` header requesters.
- Grants one requester per packet by round-robin and registers the granted header onto the insert interface.
- Holds the grant until the header-inserted packet's last beat is accepted at the stream output.
- Sits directly in front of the insert block's `valid_insert`/`data_insert`/`keep_insert`/`byte_insert_cnt`/`ready_insert` port and taps its output handshake.

---
 rtl/axi_hdr_arb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/axi_stream_header_arbiter.sv | 154 +++++++++++++++
 tb/tb_axi_stream_header_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_hdr_arb_pkg.sv
// Shared types and width helpers for axi_stream_header_arbiter and its round-robin picker.
package axi_hdr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PKT  = 2'd2
  } hdr_arb_state_t;

  // Byte-count width; kept at least 1 bit so an 8-bit bus still has a legal port.
  function automatic int bcw_f(input int data_wd);
    return (data_wd / 8 > 1) ? $clog2(data_wd / 8) : 1;
  endfunction

  function automatic int keep_w_f(input int data_wd);
    return data_wd / 8;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after ptr, wrapping modulo NUM_SRC.
module rr_arbiter #(
  parameter  int NUM_SRC = 4,
  localparam int IDW     = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_SRC-1:0] gnt,
  output logic [IDW-1:0]     gnt_id,
  output logic               any
);

  logic [IDW-1:0] idx;

  // Walk from the farthest offset to the nearest so the nearest requester overwrites last.
  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    idx    = '0;
    any    = |req;
    for (int off = NUM_SRC; off >= 1; off--) begin
      idx = IDW'((int'(ptr) + off) % NUM_SRC);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/axi_stream_header_arbiter.sv
// Round-robin owner of the header-insert port; grant is held until the inserted packet's last beat.
// Optional watchdog enabled by defining HDR_ARB_TIMEOUT_EN.
module axi_stream_header_arbiter
  import axi_hdr_arb_pkg::*;
#(
  parameter  int DATA_WD     = 16,
  parameter  int NUM_SRC     = 4,
  parameter  int TIMEOUT_CYC = 1024,
  localparam int BCW         = bcw_f(DATA_WD),
  localparam int KW          = keep_w_f(DATA_WD),
  localparam int IDW         = $clog2(NUM_SRC)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SRC-1:0]     req_valid,
  input  logic [NUM_SRC*DATA_WD-1:0] req_data,
  input  logic [NUM_SRC*KW-1:0]  req_keep,
  input  logic [NUM_SRC*BCW-1:0] req_byte_cnt,
  output logic [NUM_SRC-1:0]     req_ready,
  output logic                   valid_insert,
  output logic [DATA_WD-1:0]     data_insert,
  output logic [KW-1:0]          keep_insert,
  output logic [BCW-1:0]         byte_insert_cnt,
  input  logic                   ready_insert,
  input  logic                   mon_valid,
  input  logic                   mon_ready,
  input  logic                   mon_last,
  output logic [IDW-1:0]         grant_id,
  output logic                   grant_active,
  output logic                   timeout_err
);

  if (NUM_SRC < 2 || NUM_SRC > 16) begin : g_bad_num_src
    $error("NUM_SRC must be in 2..16");
  end
  if (DATA_WD % 8 != 0) begin : g_bad_data_wd
    $error("DATA_WD must be a multiple of 8");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  hdr_arb_state_t state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q;
  logic [IDW-1:0]     grant_id_q;
  logic [DATA_WD-1:0] data_q;
  logic [KW-1:0]      keep_q;
  logic [BCW-1:0]     bcnt_q;

  logic [NUM_SRC-1:0] rr_gnt;
  logic [IDW-1:0]     rr_id;
  logic               rr_any;

  logic [DATA_WD-1:0] sel_data;
  logic [KW-1:0]      sel_keep;
  logic [BCW-1:0]     sel_bcnt;

  logic grant_fire;
  logic hdr_acc;
  logic pkt_done;
  logic timeout_hit;

  rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .gnt    (rr_gnt),
    .gnt_id (rr_id),
    .any    (rr_any)
  );

  // Gated by rst so no source sees an accept in a cycle whose capture is discarded.
  assign grant_fire = (state_q == IDLE) & rr_any & ~rst;
  assign hdr_acc    = (state_q == HDR) & ready_insert;
  assign pkt_done   = (state_q == PKT) & mon_valid & mon_ready & mon_last;

  always_comb begin
    sel_data = '0;
    sel_keep = '0;
    sel_bcnt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_data |= req_data[i*DATA_WD +: DATA_WD] & {DATA_WD{rr_gnt[i]}};
      sel_keep |= req_keep[i*KW +: KW]           & {KW{rr_gnt[i]}};
      sel_bcnt |= req_byte_cnt[i*BCW +: BCW]     & {BCW{rr_gnt[i]}};
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_fire) state_d = HDR;
      HDR:     if (hdr_acc)    state_d = PKT;
      PKT:     if (pkt_done)   state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
    if (timeout_hit) state_d = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: header registers are reset too, because every output must read 0 straight after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= IDW'(NUM_SRC - 1);
      grant_id_q <= '0;
      data_q     <= '0;
      keep_q     <= '0;
      bcnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (grant_fire) begin
        rr_ptr_q   <= rr_id;
        grant_id_q <= rr_id;
        data_q     <= sel_data;
        keep_q     <= sel_keep;
        bcnt_q     <= sel_bcnt;
      end
    end
  end

`ifdef HDR_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] cnt_q;
  logic          timeout_q;

  // A completing last beat in the final cycle wins over the watchdog.
  assign timeout_hit = (state_q != IDLE) & (cnt_q == CW'(TIMEOUT_CYC - 1)) & ~pkt_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_hit;
      if (grant_fire)           cnt_q <= '0;
      else if (state_q != IDLE) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign req_ready       = grant_fire ? rr_gnt : '0;
  assign valid_insert    = (state_q == HDR);
  assign grant_active    = (state_q != IDLE);
  assign data_insert     = data_q;
  assign keep_insert     = keep_q;
  assign byte_insert_cnt = bcnt_q;
  assign grant_id        = grant_id_q;

endmodule

// File: tb/tb_axi_stream_header_arbiter.sv
// Directed scoreboard bench for axi_stream_header_arbiter (4 sources, 16-bit headers).
module tb_axi_stream_header_arbiter;

  localparam int DATA_WD = 16;
  localparam int NUM_SRC = 4;
  localparam int KW      = 2;
  localparam int BCW     = 1;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] data;
    logic [1:0]  keep;
    logic [0:0]  bcnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [NUM_SRC-1:0]         req_valid;
  logic [NUM_SRC*DATA_WD-1:0] req_data;
  logic [NUM_SRC*KW-1:0]      req_keep;
  logic [NUM_SRC*BCW-1:0]     req_byte_cnt;
  logic [NUM_SRC-1:0]         req_ready;
  logic                       valid_insert;
  logic [DATA_WD-1:0]         data_insert;
  logic [KW-1:0]              keep_insert;
  logic [BCW-1:0]             byte_insert_cnt;
  logic                       ready_insert;
  logic                       mon_valid, mon_ready, mon_last;
  logic [1:0]                 grant_id;
  logic                       grant_active;
  logic                       timeout_err;

  logic [15:0] src_data [NUM_SRC] = '{16'h0038, 16'hA1B2, 16'h5C3D, 16'hF00F};
  logic [1:0]  src_keep [NUM_SRC] = '{2'b11, 2'b10, 2'b11, 2'b01};
  logic [0:0]  src_bcnt [NUM_SRC] = '{1'b1, 1'b0, 1'b1, 1'b0};

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  axi_stream_header_arbiter #(
    .DATA_WD     (DATA_WD),
    .NUM_SRC     (NUM_SRC),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_keep        (req_keep),
    .req_byte_cnt    (req_byte_cnt),
    .req_ready       (req_ready),
    .valid_insert    (valid_insert),
    .data_insert     (data_insert),
    .keep_insert     (keep_insert),
    .byte_insert_cnt (byte_insert_cnt),
    .ready_insert    (ready_insert),
    .mon_valid       (mon_valid),
    .mon_ready       (mon_ready),
    .mon_last        (mon_last),
    .grant_id        (grant_id),
    .grant_active    (grant_active),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_mon(input logic v, input logic r, input logic l);
    mon_valid = v;
    mon_ready = r;
    mon_last  = l;
  endtask

  // Drives an IDLE request, checks the accept pulse and pushes the expected header.
  task automatic request(input logic [3:0] rv, input int exp_id);
    exp_t e;
    req_valid = rv;
    #1;
    check("req_ready", 32'(req_ready), 32'(1 << exp_id));
    check("idle_valid_insert", 32'(valid_insert), 32'd0);
    e.id   = 2'(exp_id);
    e.data = src_data[exp_id];
    e.keep = src_keep[exp_id];
    e.bcnt = src_bcnt[exp_id];
    sb.push_back(e);
  endtask

  // Called in the first HDR cycle: pops the scoreboard and compares the presented header.
  task automatic check_hdr(output exp_t e);
    check("hdr_valid_insert", 32'(valid_insert), 32'd1);
    check("hdr_req_ready", 32'(req_ready), 32'd0);
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL sb_empty: observed header with no expectation queued");
      e = '0;
    end else begin
      e = sb.pop_front();
      check("data_insert", 32'(data_insert), 32'(e.data));
      check("keep_insert", 32'(keep_insert), 32'(e.keep));
      check("byte_insert_cnt", 32'(byte_insert_cnt), 32'(e.bcnt));
      check("grant_id", 32'(grant_id), 32'(e.id));
    end
  endtask

  // One full grant: request in IDLE, optional HDR stall/noise, packet of `beats`, back to IDLE.
  task automatic do_packet(input logic [3:0] rv, input int exp_id, input int ready_dly,
                           input bit hdr_noise, input bit idle_noise, input int beats,
                           input bit stop_in_pkt);
    exp_t e;
    ready_insert = 1'b0;
    if (idle_noise) set_mon(1'b1, 1'b1, 1'b1);
    else            set_mon(1'b0, 1'b0, 1'b0);
    request(rv, exp_id);
    tick();
    set_mon(1'b0, 1'b0, 1'b0);
    check_hdr(e);
    for (int k = 0; k < ready_dly; k++) begin
      if (hdr_noise && k == 0) set_mon(1'b1, 1'b1, 1'b1);
      tick();
      set_mon(1'b0, 1'b0, 1'b0);
      check("stall_valid_insert", 32'(valid_insert), 32'd1);
      check("stall_data_insert", 32'(data_insert), 32'(e.data));
    end
    ready_insert = 1'b1;
    tick();
    ready_insert = 1'b0;
    check("pkt_valid_insert", 32'(valid_insert), 32'd0);
    check("pkt_grant_active", 32'(grant_active), 32'd1);
    if (stop_in_pkt) return;
    set_mon(1'b1, 1'b0, 1'b1);
    tick();
    check("pkt_no_handshake", 32'(grant_active), 32'd1);
    for (int b = 0; b < beats; b++) begin
      set_mon(1'b1, 1'b1, (b == beats - 1));
      tick();
      if (b != beats - 1) check("pkt_mid_beat", 32'(grant_active), 32'd1);
    end
    set_mon(1'b0, 1'b0, 1'b0);
    check("idle_grant_active", 32'(grant_active), 32'd0);
    check("idle_after_pkt_valid", 32'(valid_insert), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NUM_SRC; i++) begin
      req_data[i*DATA_WD +: DATA_WD] = src_data[i];
      req_keep[i*KW +: KW]           = src_keep[i];
      req_byte_cnt[i*BCW +: BCW]     = src_bcnt[i];
    end
    rst          = 1'b1;
    req_valid    = '0;
    ready_insert = 1'b0;
    set_mon(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check("rst_valid_insert", 32'(valid_insert), 32'd0);
    check("rst_data_insert", 32'(data_insert), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_grant_active", 32'(grant_active), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    tick();

    // Lone source 0, header 16'h0038 with byte count 1.
    do_packet(4'b0001, 0, 0, 1'b0, 1'b0, 2, 1'b0);
    // Five-cycle ready_insert stall in HDR.
    do_packet(4'b0100, 2, 5, 1'b0, 1'b0, 1, 1'b0);
    // Monitor handshake during HDR and during the IDLE grant cycle are both ignored.
    do_packet(4'b1000, 3, 3, 1'b1, 1'b1, 3, 1'b0);

    // Reset in the middle of a packet.
    do_packet(4'b0010, 1, 0, 1'b0, 1'b0, 1, 1'b1);
    set_mon(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    set_mon(1'b0, 1'b0, 1'b0);
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    check("midrst_valid_insert", 32'(valid_insert), 32'd0);
    check("midrst_data_insert", 32'(data_insert), 32'd0);
    check("midrst_keep_insert", 32'(keep_insert), 32'd0);
    check("midrst_byte_cnt", 32'(byte_insert_cnt), 32'd0);
    check("midrst_grant_id", 32'(grant_id), 32'd0);
    check("midrst_grant_active", 32'(grant_active), 32'd0);
    rst = 1'b0;

    // All sources held: back-to-back grants rotate 0,1,2,3,0.
    do_packet(4'b1111, 0, 0, 1'b0, 1'b0, 1, 1'b0);
    do_packet(4'b1111, 1, 1, 1'b0, 1'b0, 2, 1'b0);
    do_packet(4'b1111, 2, 0, 1'b0, 1'b0, 1, 1'b0);
    do_packet(4'b1111, 3, 2, 1'b0, 1'b0, 4, 1'b0);
    do_packet(4'b1111, 0, 0, 1'b0, 1'b0, 1, 1'b0);
    req_valid = '0;
    tick();
    check("idle_no_req_ready", 32'(req_ready), 32'd0);
    check("idle_no_grant", 32'(grant_active), 32'd0);

`ifdef HDR_ARB_TIMEOUT_EN
    begin
      exp_t e;
      request(4'b0110, 1);
      tick();
      req_valid = '0;
      check_hdr(e);
      for (int k = 0; k < 8; k++) begin
        check("to_err_early", 32'(timeout_err), 32'd0);
        check("to_active", 32'(grant_active), 32'd1);
        tick();
      end
      check("to_err_pulse", 32'(timeout_err), 32'd1);
      check("to_idle", 32'(grant_active), 32'd0);
      check("to_valid_insert", 32'(valid_insert), 32'd0);
      tick();
      check("to_err_single", 32'(timeout_err), 32'd0);
      do_packet(4'b1111, 2, 0, 1'b0, 1'b0, 1, 1'b0);
    end
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
